tt_par_rx_fifo: RTL and testbench

- Receive-side counterpart to the top-level output path: accepts bytes from an external transmitter over a 4-phase strobe/acknowledge parallel handshake.
- Buffers received bytes in a small FIFO.
- Presents buffered bytes to the on-chip consumer through a show-ahead valid/pop interface.
- Instantiated under the tt_um top with par_data_i on uio_in, par_stb_i on ui_in[0], and read data on uo_out.

---
 rtl/tt_par_rx_fifo.sv | 165 ++++++++++++++++
 tb/tb_tt_par_rx_fifo.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_par_rx_fifo.sv
// Parallel 4-phase strobe/acknowledge receiver feeding a show-ahead byte FIFO.
// Optional odd-parity check on incoming bytes is enabled by defining PARRX_PARITY_EN.
module tt_par_rx_fifo #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ena,
    input  logic [7:0]             par_data_i,
    input  logic                   par_stb_i,
`ifdef PARRX_PARITY_EN
    input  logic                   par_parity_i,
    output logic                   parity_err_o,
`endif
    output logic                   par_ack_o,
    output logic [7:0]             rd_data_o,
    output logic                   rd_valid_o,
    input  logic                   rd_pop_i,
    output logic                   full_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FullCount = CW'(DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StWaitSpace,
        StAck
    } state_e;

    state_e            state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic              stb_s;
    logic              ack_q;
    logic              fsm_push;
    logic              push_req;
    logic              wr_en;
    logic              rd_en;
    logic              full;
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q, count_d;
    logic [7:0]        mem_q [DEPTH];

    // The strobe synchroniser keeps sampling even while ena is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], par_stb_i};
        end
    end

    assign stb_s = sync_q[SYNC_STAGES-1];
    assign full  = (count_q == FullCount);

    always_comb begin
        state_d  = state_q;
        fsm_push = 1'b0;
        case (state_q)
            StIdle: begin
                if (stb_s) begin
                    if (!full) begin
                        fsm_push = 1'b1;
                        state_d  = StAck;
                    end else begin
                        state_d  = StWaitSpace;
                    end
                end
            end
            StWaitSpace: begin
                if (!full) begin
                    fsm_push = 1'b1;
                    state_d  = StAck;
                end
            end
            StAck: begin
                if (!stb_s) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign push_req = ena && fsm_push;
    assign rd_en    = ena && rd_pop_i && (count_q != '0);

`ifdef PARRX_PARITY_EN
    logic parity_ok;
    logic parity_err_q;

    // Odd parity: data plus parity bit must contain an odd number of ones.
    assign parity_ok = ^{par_data_i, par_parity_i};
    assign wr_en     = push_req && parity_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err_q <= 1'b0;
        end else if (push_req && !parity_ok) begin
            parity_err_q <= 1'b1;
        end
    end

    assign parity_err_o = parity_err_q;
`else
    assign wr_en = push_req;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ack_q   <= 1'b0;
        end else if (ena) begin
            state_q <= state_d;
            ack_q   <= (state_d == StAck);
        end
    end

    always_comb begin
        count_d = count_q;
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    // Storage is cleared on reset so the show-ahead head reads zero when empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_ptr_q] <= par_data_i;
        end
    end

    assign par_ack_o  = ack_q;
    assign rd_data_o  = mem_q[rd_ptr_q];
    assign rd_valid_o = (count_q != '0);
    assign full_o     = full;
    assign count_o    = count_q;

endmodule

// File: tb/tb_tt_par_rx_fifo.sv
// Scoreboard bench for tt_par_rx_fifo: strobe/ack transfers, FIFO order, backpressure, reset.
module tb_tt_par_rx_fifo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ena = 1'b1;
    logic [7:0] par_data = 8'h00;
    logic       par_stb = 1'b0;
    logic       rd_pop = 1'b0;
    logic       par_ack;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       full;
    logic [2:0] count;
`ifdef PARRX_PARITY_EN
    logic       par_parity = 1'b0;
    logic       parity_err;
`endif

    int total = 0;
    int bad = 0;
    logic [7:0] sb[$];

    always #5 clk = ~clk;

    tt_par_rx_fifo #(
        .DEPTH(4),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ena(ena),
        .par_data_i(par_data),
        .par_stb_i(par_stb),
`ifdef PARRX_PARITY_EN
        .par_parity_i(par_parity),
        .parity_err_o(parity_err),
`endif
        .par_ack_o(par_ack),
        .rd_data_o(rd_data),
        .rd_valid_o(rd_valid),
        .rd_pop_i(rd_pop),
        .full_o(full),
        .count_o(count)
    );

    task automatic send(input logic [7:0] d, input logic bad_par, input string name);
        int n;
        @(negedge clk);
        par_data = d;
`ifdef PARRX_PARITY_EN
        par_parity = bad_par ? ^d : ~^d;
`endif
        if (!bad_par) sb.push_back(d);
        par_stb = 1'b1;
        n = 0;
        while (par_ack !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (par_ack !== 1'b1) begin
            bad++;
            $display("FAIL %s ack_rise: ack=%b expected 1", name, par_ack);
        end
        par_stb = 1'b0;
        n = 0;
        while (par_ack !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (par_ack !== 1'b0) begin
            bad++;
            $display("FAIL %s ack_fall: ack=%b expected 0", name, par_ack);
        end
    endtask

    task automatic pop_one(input string name);
        logic [7:0] exp;
        @(negedge clk);
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL %s pop: scoreboard empty, rd_valid=%b", name, rd_valid);
        end else begin
            exp = sb.pop_front();
            if (rd_valid !== 1'b1 || rd_data !== exp) begin
                bad++;
                $display("FAIL %s pop: valid=%b data=%h expected valid=1 data=%h",
                         name, rd_valid, rd_data, exp);
            end
        end
        rd_pop = 1'b1;
        @(negedge clk);
        rd_pop = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (par_ack !== 1'b0 || rd_valid !== 1'b0 || full !== 1'b0 || count !== 3'd0 ||
            rd_data !== 8'h00) begin
            bad++;
            $display("FAIL reset_values: ack=%b valid=%b full=%b count=%0d data=%h expected 0s",
                     par_ack, rd_valid, full, count, rd_data);
        end
`ifdef PARRX_PARITY_EN
        total++;
        if (parity_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_parity_err: got %b expected 0", parity_err);
        end
`endif
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        @(negedge clk);
        par_data = 8'hA5;
`ifdef PARRX_PARITY_EN
        par_parity = ~^par_data;
`endif
        par_stb = 1'b1;
        sb.push_back(8'hA5);
        for (int e = 1; e <= 3; e++) begin
            @(negedge clk);
            total++;
            if (par_ack !== 1'(e == 3) || rd_valid !== 1'(e == 3)) begin
                bad++;
                $display("FAIL single_rise_edge%0d: ack=%b valid=%b expected %b",
                         e, par_ack, rd_valid, 1'(e == 3));
            end
        end
        total++;
        if (rd_data !== 8'hA5 || count !== 3'd1) begin
            bad++;
            $display("FAIL single_data: data=%h count=%0d expected a5 1", rd_data, count);
        end
        par_stb = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            @(negedge clk);
            total++;
            if (par_ack !== 1'(e < 3)) begin
                bad++;
                $display("FAIL single_fall_edge%0d: ack=%b expected %b", e, par_ack, 1'(e < 3));
            end
        end
        pop_one("single");
        total++;
        if (rd_valid !== 1'b0 || count !== 3'd0) begin
            bad++;
            $display("FAIL single_after_pop: valid=%b count=%0d expected 0 0", rd_valid, count);
        end
    endtask

    task automatic test_fill_order();
        logic [7:0] base;
        for (int r = 0; r < 2; r++) begin
            base = (r == 0) ? 8'h11 : 8'hC1;
            for (int i = 0; i < 4; i++) send(base + 8'(i * 17), 1'b0, "fill");
            total++;
            if (full !== 1'b1 || count !== 3'd4) begin
                bad++;
                $display("FAIL fill_full_r%0d: full=%b count=%0d expected 1 4", r, full, count);
            end
            for (int i = 0; i < 4; i++) pop_one("fill_order");
            total++;
            if (rd_valid !== 1'b0 || full !== 1'b0) begin
                bad++;
                $display("FAIL fill_drain_r%0d: valid=%b full=%b expected 0 0", r, rd_valid, full);
            end
        end
    endtask

    task automatic test_backpressure();
        int hi;
        int n;
        logic [7:0] exp;
        for (int i = 0; i < 4; i++) send(8'hA1 + 8'(i), 1'b0, "bp_fill");
        @(negedge clk);
        par_data = 8'h55;
`ifdef PARRX_PARITY_EN
        par_parity = ~^par_data;
`endif
        par_stb = 1'b1;
        sb.push_back(8'h55);
        hi = 0;
        repeat (20) begin
            @(negedge clk);
            if (par_ack !== 1'b0) hi++;
        end
        total++;
        if (hi != 0 || count !== 3'd4) begin
            bad++;
            $display("FAIL bp_stall: ack-high cycles=%0d count=%0d expected 0 4", hi, count);
        end
        exp = sb.pop_front();
        total++;
        if (rd_data !== exp) begin
            bad++;
            $display("FAIL bp_head: data=%h expected %h", rd_data, exp);
        end
        rd_pop = 1'b1;
        @(negedge clk);
        rd_pop = 1'b0;
        total++;
        if (par_ack !== 1'b0 || count !== 3'd3) begin
            bad++;
            $display("FAIL bp_after_pop: ack=%b count=%0d expected 0 3", par_ack, count);
        end
        @(negedge clk);
        total++;
        if (par_ack !== 1'b1 || count !== 3'd4) begin
            bad++;
            $display("FAIL bp_push_lag: ack=%b count=%0d expected 1 4", par_ack, count);
        end
        par_stb = 1'b0;
        n = 0;
        while (par_ack !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (par_ack !== 1'b0) begin
            bad++;
            $display("FAIL bp_ack_fall: ack=%b expected 0", par_ack);
        end
        for (int i = 0; i < 4; i++) pop_one("bp_drain");
    endtask

    task automatic test_back_to_back();
        int n;
        logic [7:0] exp;
        @(negedge clk);
        rd_pop = 1'b1;
        @(negedge clk);
        rd_pop = 1'b0;
        total++;
        if (count !== 3'd0 || rd_valid !== 1'b0) begin
            bad++;
            $display("FAIL empty_pop: count=%0d valid=%b expected 0 0", count, rd_valid);
        end
        send(8'h70, 1'b0, "b2b");
        send(8'h71, 1'b0, "b2b");
        @(negedge clk);
        par_data = 8'h66;
`ifdef PARRX_PARITY_EN
        par_parity = ~^par_data;
`endif
        par_stb = 1'b1;
        sb.push_back(8'h66);
        @(negedge clk);
        @(negedge clk);
        exp = sb.pop_front();
        total++;
        if (rd_data !== exp) begin
            bad++;
            $display("FAIL b2b_head: data=%h expected %h", rd_data, exp);
        end
        rd_pop = 1'b1;
        @(negedge clk);
        rd_pop = 1'b0;
        total++;
        if (count !== 3'd2 || par_ack !== 1'b1 || rd_data !== sb[0]) begin
            bad++;
            $display("FAIL b2b_simul: count=%0d ack=%b data=%h expected 2 1 %h",
                     count, par_ack, rd_data, sb[0]);
        end
        par_stb = 1'b0;
        n = 0;
        while (par_ack !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        pop_one("b2b");
        pop_one("b2b");
    endtask

    task automatic test_reset_mid();
        int n;
        @(negedge clk);
        par_data = 8'h99;
`ifdef PARRX_PARITY_EN
        par_parity = ~^par_data;
`endif
        par_stb = 1'b1;
        n = 0;
        while (par_ack !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (par_ack !== 1'b0 || count !== 3'd0 || rd_valid !== 1'b0 || rd_data !== 8'h00) begin
            bad++;
            $display("FAIL rst_mid_async: ack=%b count=%0d valid=%b data=%h expected 0 0 0 00",
                     par_ack, count, rd_valid, rd_data);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        sb.push_back(8'h99);
        for (int e = 1; e <= 3; e++) begin
            @(negedge clk);
            total++;
            if (par_ack !== 1'(e == 3)) begin
                bad++;
                $display("FAIL rst_mid_reack_edge%0d: ack=%b expected %b", e, par_ack, 1'(e == 3));
            end
        end
        par_stb = 1'b0;
        n = 0;
        while (par_ack !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        pop_one("rst_mid");
    endtask

    task automatic test_enable();
        int n;
        @(negedge clk);
        ena = 1'b0;
        par_data = 8'h3C;
`ifdef PARRX_PARITY_EN
        par_parity = ~^par_data;
`endif
        par_stb = 1'b1;
        repeat (5) @(negedge clk);
        total++;
        if (par_ack !== 1'b0 || count !== 3'd0) begin
            bad++;
            $display("FAIL ena_hold: ack=%b count=%0d expected 0 0", par_ack, count);
        end
        ena = 1'b1;
        sb.push_back(8'h3C);
        @(negedge clk);
        total++;
        if (par_ack !== 1'b1 || count !== 3'd1) begin
            bad++;
            $display("FAIL ena_resume: ack=%b count=%0d expected 1 1", par_ack, count);
        end
        par_stb = 1'b0;
        n = 0;
        while (par_ack !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        ena = 1'b0;
        rd_pop = 1'b1;
        repeat (2) @(negedge clk);
        rd_pop = 1'b0;
        ena = 1'b1;
        total++;
        if (count !== 3'd1 || rd_data !== 8'h3C) begin
            bad++;
            $display("FAIL ena_pop_ignored: count=%0d data=%h expected 1 3c", count, rd_data);
        end
        pop_one("ena");
    endtask

`ifdef PARRX_PARITY_EN
    task automatic test_parity();
        send(8'h01, 1'b1, "par_bad");
        total++;
        if (parity_err !== 1'b1 || count !== 3'd0) begin
            bad++;
            $display("FAIL parity_bad: err=%b count=%0d expected 1 0", parity_err, count);
        end
        send(8'h01, 1'b0, "par_good");
        total++;
        if (parity_err !== 1'b1 || count !== 3'd1) begin
            bad++;
            $display("FAIL parity_good: err=%b count=%0d expected 1 1", parity_err, count);
        end
        pop_one("parity");
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_fill_order();
        test_backpressure();
        test_back_to_back();
        test_enable();
        test_reset_mid();
`ifdef PARRX_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
